fetch_buffer: RTL

Instruction fetch stage directly downstream of the program counter. Drives the synchronous instruction ROM from the current PC, captures each returned instruction with its PC, and buffers it in a small FIFO. The buffer presents instructions to decode through a valid/ready handshake. It also returns a hold to the PC when the buffer has no space, and discards wrong-path instructions on a flush (taken absolute jump).

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_buffer.sv | 76 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: PC, instruction and the
// {pc, instr} entry carried through the fetch buffer.
package fetch_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 9;

    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetch entries with synchronous clear. The caller guarantees
// no push when full and no pop when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: storage is reset too, so the head reads as zero out of reset
            // rather than X; with DEPTH this small the cost is negligible.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues ROM reads from the PC, pairs each returned instruction
// with its PC, buffers it for decode, holds the PC when full and flushes on jumps.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int D     = PC_W,
    parameter int W     = INSTR_W,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [D-1:0] prog_ctr,
    input  logic         flush,
    output logic [D-1:0] imem_addr,
    output logic         imem_en,
    input  logic [W-1:0] imem_rdata,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_instr,
    output logic [D-1:0] out_pc,
    output logic         pc_hold
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = $clog2(DEPTH + 2);

    logic [CNT_W-1:0] count;
    logic [OCC_W-1:0] occupancy;
    logic             inflight;
    pc_t              pc_q;
    logic             pop;
    logic             push;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    // Slots committed after this cycle: buffered plus the read returning now,
    // minus the entry decode takes this cycle.
    assign occupancy = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    assign pc_hold   = !flush && (occupancy >= OCC_W'(DEPTH));
    assign imem_en   = !pc_hold;
    assign imem_addr = prog_ctr;

    // A return during a jump belongs to the old path and is dropped.
    assign push       = inflight & !flush;
    assign push_entry = '{pc: pc_q, instr: imem_rdata};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            pc_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values of its neighbours.
            inflight <= imem_en & !flush;
            if (imem_en) pc_q <= prog_ctr;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (push_entry),
        .head  (head),
        .count (count)
    );

    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule
